// File: rtl/wb_serial_adder.sv
// Wishbone-slave 32-bit bit-serial adder: operands A and B are summed one bit per
// cycle into RESULT, with a completion interrupt.
module wb_serial_adder #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [2:0]  irq
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

  state_t      state_r;
  logic [31:0] a_r, b_r, result_r;
  logic [31:0] sa_r, sb_r, sum_sh_r;
  logic [4:0]  cnt_r;
  logic        cin_r, carry_r, done_r, irq_en_r, irq_r, ack_r;
  logic [31:0] dat_r;

  logic        hit_s, acc_s, wr_s, start_s, busy_s, sum_bit_s, cout_s;
  logic [1:0]  off_s;
  logic [31:0] rd_data_s;
  logic        unused_s;

  assign unused_s  = ^wbs_adr_i[1:0];
  assign hit_s     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  // A request is accepted only on a cycle not already acked, so ack never repeats back-to-back.
  assign acc_s     = hit_s & ~ack_r;
  assign wr_s      = acc_s & wbs_we_i;
  assign off_s     = wbs_adr_i[3:2];
  assign busy_s    = (state_r == RUN);
  assign start_s   = wr_s & (off_s == 2'd2) & wbs_dat_i[0] & ~busy_s;
  assign sum_bit_s = sa_r[0] ^ sb_r[0] ^ cin_r;
  assign cout_s    = maj3(sa_r[0], sb_r[0], cin_r);

  assign wbs_ack_o = ack_r;
  assign wbs_dat_o = dat_r;
  assign irq       = {2'b00, irq_r};

  // Register read multiplexer.
  always_comb begin
    rd_data_s = 32'h0;
    case (off_s)
      2'd0:    rd_data_s = a_r;
      2'd1:    rd_data_s = b_r;
      2'd2:    rd_data_s = {28'h0, carry_r, done_r, irq_en_r, busy_s};
      2'd3:    rd_data_s = result_r;
      default: rd_data_s = 32'h0;
    endcase
  end

  // Bus acknowledge and read-data register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_r <= 1'b0;
      dat_r <= 32'h0;
    end else begin
      ack_r <= acc_s;
      dat_r <= (acc_s & ~wbs_we_i) ? rd_data_s : 32'h0;
    end
  end

  // Register file writes, serial-add FSM and interrupt.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_r  <= IDLE;
      a_r      <= 32'h0;
      b_r      <= 32'h0;
      result_r <= 32'h0;
      sa_r     <= 32'h0;
      sb_r     <= 32'h0;
      sum_sh_r <= 32'h0;
      cnt_r    <= 5'd0;
      cin_r    <= 1'b0;
      carry_r  <= 1'b0;
      done_r   <= 1'b0;
      irq_en_r <= 1'b0;
      irq_r    <= 1'b0;
    end else begin
      irq_r <= done_r & irq_en_r;
      if (wr_s) begin
        case (off_s)
          2'd0: if (!busy_s) a_r <= byte_merge(a_r, wbs_dat_i, wbs_sel_i);
          2'd1: if (!busy_s) b_r <= byte_merge(b_r, wbs_dat_i, wbs_sel_i);
          2'd2: begin
            irq_en_r <= wbs_dat_i[1];
            if (wbs_dat_i[2]) done_r <= 1'b0;
          end
          default: ;
        endcase
      end
      // Completion is evaluated after the CTRL write so that it wins over a done-clear.
      case (state_r)
        IDLE: ;
        RUN: begin
          sa_r     <= {1'b0, sa_r[31:1]};
          sb_r     <= {1'b0, sb_r[31:1]};
          sum_sh_r <= {sum_bit_s, sum_sh_r[31:1]};
          cin_r    <= cout_s;
          cnt_r    <= cnt_r + 5'd1;
          if (cnt_r == 5'd31) state_r <= DONE;
        end
        DONE: begin
          state_r  <= IDLE;
          done_r   <= 1'b1;
          carry_r  <= cin_r;
          result_r <= sum_sh_r;
        end
        default: state_r <= IDLE;
      endcase
      if (start_s) begin
        state_r <= RUN;
        sa_r    <= a_r;
        sb_r    <= b_r;
        cin_r   <= 1'b0;
        cnt_r   <= 5'd0;
        if (state_r != DONE) done_r <= 1'b0;
      end
    end
  end

endmodule

// File: doc/wb_serial_adder.md
WB_SERIAL_ADDER -- requirements
Module: wb_serial_adder

Interface
REQ-001 The module SHALL have parameter BASE_ADDR, default 32'h3000_0000, the 16-byte-aligned base of the register window.
REQ-002 The module SHALL have port wb_clk_i, input, 1 bit: the single clock; all logic rises on its positive edge.
REQ-003 The module SHALL have port wb_rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-004 The module SHALL have port wbs_stb_i, input, 1 bit: Wishbone strobe.
REQ-005 The module SHALL have port wbs_cyc_i, input, 1 bit: Wishbone cycle.
REQ-006 The module SHALL have port wbs_we_i, input, 1 bit: write enable.
REQ-007 The module SHALL have port wbs_sel_i, input, 4 bits: byte selects.
REQ-008 The module SHALL have port wbs_dat_i, input, 32 bits: write data.
REQ-009 The module SHALL have port wbs_adr_i, input, 32 bits: byte address.
REQ-010 The module SHALL have port wbs_ack_o, output, 1 bit: transfer acknowledge.
REQ-011 The module SHALL have port wbs_dat_o, output, 32 bits: read data.
REQ-012 The module SHALL have port irq, output, 3 bits: irq[0] completion interrupt, irq[2:1] tied 0.

Function
REQ-013 The module SHALL treat a request as hit when wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]); register offset = wbs_adr_i[3:2].
REQ-014 The module SHALL assert wbs_ack_o for exactly one cycle, in the cycle after the first hit cycle, never on two consecutive cycles, and never for non-hit requests.
REQ-015 The module SHALL perform register write side effects at the clock edge that asserts wbs_ack_o, and SHALL drive wbs_dat_o with read data only while wbs_ack_o=1, else 32'h0.
REQ-016 Offset 0 (A, RW) and offset 1 (B, RW) SHALL update only the bytes enabled by wbs_sel_i; writes while busy SHALL be acked but ignored.
REQ-017 Offset 2 (CTRL) SHALL use the following bits:
- write bit0 = start
- write bit1 = irq_en (stored)
- write bit2 = 1 clears done
- read {28'b0, carry, done, irq_en, busy}
REQ-018 Offset 3 (RESULT, RO) SHALL return the 32-bit sum; writes to it SHALL be acked and ignored.
REQ-019 The FSM SHALL have states IDLE, RUN and DONE.
- IDLE->RUN: on start write, only if not in RUN; latch A and B into shift registers; carry_int=0; bit counter=0; clear done.
- RUN: one bit per cycle, LSB first; sum bit = a^b^c, c' = majority(a,b,c); shift the sum bit into RESULT from the MSB end.
- RUN->DONE: after exactly 32 RUN cycles.
- DONE->IDLE: unconditionally, in the next cycle; on that transition set done=1 and carry=final carry.
REQ-020 busy SHALL equal (state==RUN).
REQ-021 Latency SHALL be fixed: done reads 1 from the 34th cycle after the start-ack edge.
REQ-022 A start while in RUN SHALL be ignored; a start in DONE or IDLE SHALL begin a new operation.
REQ-023 RESULT and carry SHALL hold their last completed values until the next operation completes; partial RESULT contents during RUN are undefined to software.
REQ-024 The sum SHALL be modulo 2^32, with the overflow bit reported in carry.
REQ-025 irq[0] SHALL equal done & irq_en, registered, and SHALL remain asserted until done is cleared or irq_en is written 0.
REQ-026 If a start-with-bit2 write and completion coincide, completion SHALL win (done=1).

Reset
REQ-027 While wb_rst_i=1 at a clock edge, the module SHALL set:
- state=IDLE
- A, B, RESULT = 0
- carry, done, irq_en = 0
- wbs_ack_o=0, wbs_dat_o=0, irq=3'b000
REQ-028 Reset during RUN SHALL abort the operation without setting done.
REQ-029 A Wishbone request present during reset SHALL NOT be acked until the first cycle after wb_rst_i falls.

Verification
REQ-030 Basic add: write A=5, B=3, CTRL=1, then poll -> busy=1 for 32 cycles, then CTRL reads 4'b0100, RESULT=8, carry=0.
REQ-031 Overflow: A=32'hFFFF_FFFF, B=1, start -> RESULT=0, carry=1; A=32'h8000_0000, B=32'h8000_0000 -> RESULT=0, carry=1.
REQ-032 Byte select: A=0, then write 32'hAABBCCDD with sel=4'b0101 -> A reads 32'h00BB00DD.
REQ-033 Busy protection: start A=1, B=2; at RUN cycle 10 write A=7 and CTRL=1 -> both acked, RESULT=3, done set once at cycle 34.
REQ-034 Interrupt: CTRL=2'b11, completion -> irq=3'b001; write CTRL bit2=1 -> irq=0 the cycle after the ack.
REQ-035 Reset mid-run: assert wb_rst_i at RUN cycle 5 -> all registers 0, busy=0, done=0, irq=0; a non-hit address is never acked.
